// File: rtl/ides_align_pkg.sv
// Shared types and defaults for the IDES4 word aligner.
// Counter widths are sized to cover the full legal range of each parameter.
`timescale 1ns/1ps
package ides_align_pkg;

    typedef enum logic [2:0] {
        SEARCH,
        SLIP,
        SETTLE,
        VERIFY,
        LOCKED
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF     = 8'h47;
    localparam int         LOCK_COUNT_DEF    = 4;
    localparam int         SEARCH_WINDOW_DEF = 16;
    localparam int         SLIP_SETTLE_DEF   = 4;

    // LOCK_COUNT 1..15, SEARCH_WINDOW 2..255, SLIP_SETTLE 1..15
    localparam int MATCH_W  = 4;
    localparam int WIN_W    = 8;
    localparam int SETTLE_W = 4;

endpackage

// File: rtl/ides4_word_aligner.sv
// Bit/nibble aligner behind a Gowin IDES4: bitslips via CALIB until the training
// byte is seen LOCK_COUNT times on consecutive byte cycles, then streams aligned bytes.
`timescale 1ns/1ps
module ides4_word_aligner
    import ides_align_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
    parameter int         LOCK_COUNT    = LOCK_COUNT_DEF,
    parameter int         SEARCH_WINDOW = SEARCH_WINDOW_DEF,
    parameter int         SLIP_SETTLE   = SLIP_SETTLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] q_i,
    input  logic       relock_i,
    output logic       calib_o,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       locked_o,
    output logic [1:0] slip_cnt_o
);

    localparam logic [WIN_W-1:0]    WIN_LAST    = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SLIP_SETTLE - 1);
    localparam logic                DIRECT_LOCK = (LOCK_COUNT == 1);

    state_t              state, next_state;
    logic [3:0]          prev_q;
    logic [WIN_W-1:0]    win_cnt, win_nxt;
    logic [MATCH_W-1:0]  match_cnt, match_nxt;
    logic [SETTLE_W-1:0] set_cnt, set_nxt;
    logic                byte_ph, ph_nxt;
    logic                emit;
    logic [7:0]          cand;
    logic                is_sync;

    // The later nibble forms the upper half of the candidate byte.
    assign cand    = {q_i, prev_q};
    assign is_sync = (cand == SYNC_BYTE);

    always_comb begin
        next_state = state;
        win_nxt    = win_cnt;
        match_nxt  = match_cnt;
        set_nxt    = set_cnt;
        ph_nxt     = ~byte_ph;
        emit       = 1'b0;
        case (state)
            SEARCH: begin
                win_nxt = win_cnt + 1'b1;
                if (relock_i) begin
                    win_nxt   = '0;
                    match_nxt = '0;
                end else if (is_sync) begin
                    // This cycle is a byte cycle, so the next one is not.
                    ph_nxt     = 1'b0;
                    match_nxt  = MATCH_W'(1);
                    next_state = DIRECT_LOCK ? LOCKED : VERIFY;
                end else if (win_cnt == WIN_LAST) begin
                    next_state = SLIP;
                end
            end
            SLIP: begin
                next_state = SETTLE;
                set_nxt    = '0;
            end
            SETTLE: begin
                if (set_cnt == SETTLE_LAST) begin
                    next_state = SEARCH;
                    win_nxt    = '0;
                end else begin
                    set_nxt = set_cnt + 1'b1;
                end
            end
            VERIFY: begin
                if (relock_i) begin
                    next_state = SEARCH;
                    win_nxt    = '0;
                    match_nxt  = '0;
                end else if (byte_ph) begin
                    if (!is_sync) begin
                        next_state = SEARCH;
                        win_nxt    = '0;
                        match_nxt  = '0;
                    end else if (match_cnt == MATCH_LAST) begin
                        next_state = LOCKED;
                    end else begin
                        match_nxt = match_cnt + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (relock_i) begin
                    next_state = SEARCH;
                    win_nxt    = '0;
                    match_nxt  = '0;
                end else begin
                    emit = byte_ph;
                end
            end
            default: next_state = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= SEARCH;
            prev_q       <= '0;
            win_cnt      <= '0;
            match_cnt    <= '0;
            set_cnt      <= '0;
            byte_ph      <= 1'b0;
            calib_o      <= 1'b0;
            byte_o       <= '0;
            byte_valid_o <= 1'b0;
            locked_o     <= 1'b0;
            slip_cnt_o   <= '0;
        end else begin
            state        <= next_state;
            prev_q       <= q_i;
            win_cnt      <= win_nxt;
            match_cnt    <= match_nxt;
            set_cnt      <= set_nxt;
            byte_ph      <= ph_nxt;
            // CALIB is high exactly during the single SLIP cycle.
            calib_o      <= (next_state == SLIP);
            locked_o     <= (next_state == LOCKED);
            byte_valid_o <= emit;
            if (emit) begin
                byte_o <= cand;
            end
            if (next_state == SLIP) begin
                slip_cnt_o <= slip_cnt_o + 2'd1;
            end
        end
    end

endmodule
